// File: rtl/mcs51_bus_if.sv
// rtl/mcs51_bus_if.sv - request/done handshake plus 8051-style multiplexed bus pins
interface mcs51_bus_if;
  logic        i_req;
  logic        i_we;
  logic [15:0] i_addr;
  logic [7:0]  i_wdata;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_rdata;
  logic [7:0]  ad_dout;
  logic        ad_oe;
  logic [7:0]  ad_din;
  logic [7:0]  o_ah;
  logic        o_ale;
  logic        o_wr;
  logic        o_rd;
  wire  [7:0]  io_ad;

  // Resolved AD bus: the master's enable selects its drive, otherwise the far side's.
  assign io_ad = ad_oe ? ad_dout : ad_din;

  modport master (
    input  i_req, i_we, i_addr, i_wdata, io_ad,
    output o_busy, o_done, o_rdata, ad_dout, ad_oe, o_ah, o_ale, o_wr, o_rd
  );

  modport slave (
    output i_req, i_we, i_addr, i_wdata, ad_din,
    input  o_busy, o_done, o_rdata, ad_dout, ad_oe, o_ah, o_ale, o_wr, o_rd, io_ad
  );
endinterface

// File: rtl/mcs51_bus_master.sv
// rtl/mcs51_bus_master.sv - one full multiplexed ALE/WR/RD bus cycle per accepted request
module mcs51_bus_master #(
  parameter int ALE_CYC   = 2,
  parameter int AHOLD_CYC = 1,
  parameter int SETUP_CYC = 1,
  parameter int STB_CYC   = 3,
  parameter int HOLD_CYC  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  mcs51_bus_if.master bus
);
  localparam int CW = 8;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_AHOLD, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          we_q, we_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [7:0]    dout_q, dout_d;
  logic [7:0]    ah_q, ah_d;
  logic          oe_q, oe_d;
  logic          ale_q, ale_d;
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      dout_q  <= '0;
      ah_q    <= '0;
      oe_q    <= 1'b0;
      ale_q   <= 1'b0;
      wr_q    <= 1'b1;
      rd_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      dout_q  <= dout_d;
      ah_q    <= ah_d;
      oe_q    <= oe_d;
      ale_q   <= ale_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    if (state == S_IDLE) begin
      if (bus.i_req) begin
        state_d = S_ADDR;
        cnt_d   = CW'(ALE_CYC - 1);
        we_d    = bus.i_we;
        addr_d  = bus.i_addr;
        wdata_d = bus.i_wdata;
      end
    end else if (cnt != '0) begin
      cnt_d = cnt - 1'b1;
    end else begin
      // Counter expired: advance and reload with the next phase's length.
      case (state)
        S_ADDR:   begin state_d = S_AHOLD;  cnt_d = CW'(AHOLD_CYC - 1); end
        S_AHOLD:  begin state_d = S_SETUP;  cnt_d = CW'(SETUP_CYC - 1); end
        S_SETUP:  begin state_d = S_STROBE; cnt_d = CW'(STB_CYC - 1);   end
        S_STROBE: begin state_d = S_HOLD;   cnt_d = CW'(HOLD_CYC - 1);  end
        default:  begin state_d = S_IDLE;   cnt_d = '0;                 end
      endcase
    end

    if (state == S_STROBE && cnt == '0 && !we_q)
      rdata_d = bus.io_ad;

    // Pin values are derived from the next state so every output comes straight from a flop.
    ale_d  = (state_d == S_ADDR);
    wr_d   = !(state_d == S_STROBE && we_d);
    rd_d   = !(state_d == S_STROBE && !we_d);
    busy_d = (state_d != S_IDLE);
    done_d = (state == S_HOLD) && (state_d == S_IDLE);
    ah_d   = (state_d == S_IDLE) ? ah_q : addr_d[15:8];

    case (state_d)
      S_ADDR, S_AHOLD:          begin oe_d = 1'b1; dout_d = addr_d[7:0]; end
      S_SETUP, S_STROBE, S_HOLD: begin oe_d = we_d; dout_d = wdata_d;    end
      default:                  begin oe_d = 1'b0; dout_d = dout_q;      end
    endcase
  end

  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
  assign bus.o_rdata = rdata_q;
  assign bus.ad_dout = dout_q;
  assign bus.ad_oe   = oe_q;
  assign bus.o_ah    = ah_q;
  assign bus.o_ale   = ale_q;
  assign bus.o_wr    = wr_q;
  assign bus.o_rd    = rd_q;
endmodule

// File: tb/tb_mcs51_bus_master.sv
// tb/tb_mcs51_bus_master.sv - directed and random bus cycles against a peripheral and memory model
module tb_mcs51_bus_master;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   viol;

  mcs51_bus_if bus ();

  mcs51_bus_master dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h02) ? 8'h3C : (a ^ 8'hC3) + 8'h11;
  endfunction

  // Peripheral model: latches address on ALE fall, write data on WR fall, drives AD while RD low.
  logic [7:0]  pmem [0:255];
  logic        prev_ale, prev_wr, prev_rd, periph_en;
  logic [7:0]  prev_ad, ad_at_ale, wr_data_p;
  logic [15:0] lat_addr, wr_addr_p, rd_addr_p;
  int          ale_cnt, wr_cnt, rd_cnt, ale_len, wr_len, rd_len;

  always @(negedge clk) begin
    prev_ale <= bus.o_ale;
    prev_wr  <= bus.o_wr;
    prev_rd  <= bus.o_rd;
    prev_ad  <= bus.io_ad;
    if (rst) begin
      ale_cnt   <= 0;
      wr_cnt    <= 0;
      rd_cnt    <= 0;
      periph_en <= 1'b0;
      bus.ad_din <= 8'h00;
      for (int i = 0; i < 256; i++) pmem[i] <= init_val(8'(i));
    end else begin
      assert (!(bus.o_wr == 1'b0 && bus.o_rd == 1'b0) &&
              !(bus.o_ale && !(bus.o_wr && bus.o_rd)) &&
              !(bus.ad_oe && (periph_en || !bus.o_rd)))
      else begin
        viol <= viol + 1;
        $error("FAIL protocol wr=%b rd=%b ale=%b oe=%b periph=%b", bus.o_wr, bus.o_rd, bus.o_ale, bus.ad_oe, periph_en);
      end
      if (bus.o_ale) begin
        ale_cnt   <= ale_cnt + 1;
        ad_at_ale <= bus.io_ad;
      end
      if (prev_ale && !bus.o_ale) begin
        lat_addr <= {bus.o_ah, bus.io_ad};
        ale_len  <= ale_cnt;
        ale_cnt  <= 0;
      end
      if (!bus.o_wr) wr_cnt <= wr_cnt + 1;
      if (prev_wr && !bus.o_wr) begin
        pmem[lat_addr[7:0]] <= prev_ad;
        wr_addr_p <= lat_addr;
        wr_data_p <= prev_ad;
      end
      if (!prev_wr && bus.o_wr) begin
        wr_len <= wr_cnt;
        wr_cnt <= 0;
      end
      if (!bus.o_rd) begin
        rd_cnt     <= rd_cnt + 1;
        periph_en  <= 1'b1;
        bus.ad_din <= pmem[lat_addr[7:0]];
      end else begin
        periph_en <= 1'b0;
      end
      if (prev_rd && !bus.o_rd) rd_addr_p <= lat_addr;
      if (!prev_rd && bus.o_rd) begin
        rd_len <= rd_cnt;
        rd_cnt <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-addressed store keyed by the low address byte.
  logic [7:0] ref_mem [0:255];
  logic [7:0] last_rdata;

  task automatic ref_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    last_rdata = 8'h00;
  endtask

  task automatic wait_done(output int n);
    logic got;
    n   = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      #1;
      if (bus.o_done === 1'b1) got = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.o_busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", {31'd0, bus.o_busy}, 32'd0);
  endtask

  task automatic check_cycle(input logic w, input logic [15:0] a, input logic [7:0] d);
    chk("ale_len", ale_len, 2);
    chk("ad_at_ale", ad_at_ale, a[7:0]);
    chk("ah_hold", bus.o_ah, a[15:8]);
    chk("protocol", viol, 0);
    if (w) begin
      ref_mem[a[7:0]] = d;
      chk("wr_addr", wr_addr_p, a);
      chk("wr_setup_data", wr_data_p, d);
      chk("wr_len", wr_len, 3);
      chk("rdata_kept", bus.o_rdata, last_rdata);
    end else begin
      last_rdata = ref_mem[a[7:0]];
      chk("rd_addr", rd_addr_p, a);
      chk("rd_len", rd_len, 3);
      chk("rdata", bus.o_rdata, last_rdata);
    end
  endtask

  task automatic do_txn(input logic w, input logic [15:0] a, input logic [7:0] d);
    int n;
    wait_idle();
    bus.i_req   = 1'b1;
    bus.i_we    = w;
    bus.i_addr  = a;
    bus.i_wdata = d;
    @(posedge clk);
    #1;
    bus.i_req   = 1'b0;
    bus.i_we    = 1'($urandom);
    bus.i_addr  = 16'($urandom);
    bus.i_wdata = 8'($urandom);
    chk("busy_accept", {31'd0, bus.o_busy}, 32'd1);
    wait_done(n);
    chk("latency", n, 8);
    check_cycle(w, a, d);
  endtask

  initial begin
    int n;
    int dones;
    logic        w;
    logic [15:0] a;
    logic [7:0]  d;
    total = 0;
    bad   = 0;
    viol  = 0;
    rst   = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_we    = 1'b0;
    bus.i_addr  = 16'h0000;
    bus.i_wdata = 8'h00;
    ref_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ale", {31'd0, bus.o_ale}, 32'd0);
    chk("rst_wr", {31'd0, bus.o_wr}, 32'd1);
    chk("rst_rd", {31'd0, bus.o_rd}, 32'd1);
    chk("rst_oe", {31'd0, bus.ad_oe}, 32'd0);
    chk("rst_ah", bus.o_ah, 8'h00);
    chk("rst_rdata", bus.o_rdata, 8'h00);
    chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst_done", {31'd0, bus.o_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_txn(1'b1, 16'h0001, 8'hA5);
    chk("led_reg", pmem[8'h01], 8'hA5);
    do_txn(1'b0, 16'h0002, 8'h00);

    // Back-to-back: request held across the done cycle.
    wait_idle();
    bus.i_req   = 1'b1;
    bus.i_we    = 1'b1;
    bus.i_addr  = 16'h0001;
    bus.i_wdata = 8'h5A;
    @(posedge clk);
    #1;
    bus.i_we    = 1'b0;
    bus.i_addr  = 16'h0002;
    bus.i_wdata = 8'h00;
    wait_done(n);
    chk("b2b_lat1", n, 8);
    check_cycle(1'b1, 16'h0001, 8'h5A);
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
    chk("b2b_ale", {31'd0, bus.o_ale}, 32'd1);
    chk("b2b_busy", {31'd0, bus.o_busy}, 32'd1);
    wait_done(n);
    chk("b2b_lat2", n, 8);
    check_cycle(1'b0, 16'h0002, 8'h00);

    // Request pulsed mid-strobe must be dropped.
    wait_idle();
    bus.i_req   = 1'b1;
    bus.i_we    = 1'b1;
    bus.i_addr  = 16'h1203;
    bus.i_wdata = 8'h77;
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
    n = 0;
    while (bus.o_wr !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_seen", {31'd0, bus.o_wr}, 32'd0);
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h3404;
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) dones++;
    end
    chk("single_done", dones, 1);
    chk("ignored_req_addr", wr_addr_p, 16'h1203);
    ref_mem[8'h03] = 8'h77;

    repeat (24) begin
      w = 1'($urandom);
      a = {8'($urandom), 5'd0, 3'($urandom_range(0, 7))};
      d = 8'($urandom);
      do_txn(w, a, d);
    end

    // Reset during a write strobe aborts immediately.
    wait_idle();
    bus.i_req   = 1'b1;
    bus.i_we    = 1'b1;
    bus.i_addr  = 16'h0001;
    bus.i_wdata = 8'hC3;
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
    n = 0;
    while (bus.o_wr !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_wr", {31'd0, bus.o_wr}, 32'd1);
    chk("abort_ale", {31'd0, bus.o_ale}, 32'd0);
    chk("abort_oe", {31'd0, bus.ad_oe}, 32'd0);
    chk("abort_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("abort_done", {31'd0, bus.o_done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_reset();
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) dones++;
    end
    chk("abort_no_done", dones, 0);
    do_txn(1'b0, 16'h0002, 8'h00);
    do_txn(1'b1, 16'h0006, 8'h9E);
    do_txn(1'b0, 16'h0006, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
